// File: rtl/deserializer.sv
// -----------------------------------------------------------------------------
// deserializer
//
// Serial-to-parallel converter that sits in front of the priority encoder.
// It accepts one serial bit on every clock edge where data_val_i is high and
// assembles WIDTH accepted bits into one parallel word. When the word is
// complete it is presented on deser_data_o together with a one-cycle
// deser_data_val_o strobe. Gaps in the valid stream are tolerated: the
// assembly state simply holds while data_val_i is low.
//
// Bit order:
//   default                    MSB first: first accepted bit -> deser_data_o[WIDTH-1]
//   `define DESER_LSB_FIRST_EN LSB first: first accepted bit -> deser_data_o[0]
//
// Parameters:
//   WIDTH  parallel word width in bits (must be >= 2)
//
// Ports:
//   clk_i             in   clock, rising edge
//   srst_i            in   reset, asynchronous, active-high
//   data_i            in   serial data bit
//   data_val_i        in   data_i is valid this cycle
//   deser_data_o      out  last completed parallel word (WIDTH bits)
//   deser_data_val_o  out  one-cycle strobe, deser_data_o holds a new word
//   busy_o            out  high while 1..WIDTH-1 bits of a word are collected
// -----------------------------------------------------------------------------
module deserializer #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic             data_i,
    input  logic             data_val_i,
    output logic [WIDTH-1:0] deser_data_o,
    output logic             deser_data_val_o,
    output logic             busy_o
);

    // Bit-counter width is derived from WIDTH and not meant to be overridden.
    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    // Only WIDTH-1 bits need storing: the last bit of a word is taken
    // straight from data_i on the completing edge.
    logic [WIDTH-2:0] shift_reg;
    logic [WIDTH-2:0] shift_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [WIDTH-1:0] word_reg;
    logic [WIDTH-1:0] word_next;
    logic             val_reg;
    logic             val_next;
    logic             busy_reg;
    logic             busy_next;

    // Stored bits merged with the incoming bit. This is both the word that
    // is loaded on completion and the source of the shifted partial word.
    logic [WIDTH-1:0] full_word;
    logic [WIDTH-2:0] shifted;

`ifdef DESER_LSB_FIRST_EN
    // New bits enter at the top and move down; after WIDTH accepts the
    // first bit has reached position 0.
    assign full_word = {data_i, shift_reg};
    assign shifted   = full_word[WIDTH-1:1];
`else
    // New bits enter at the bottom and move up; after WIDTH accepts the
    // first bit has reached position WIDTH-1.
    assign full_word = {shift_reg, data_i};
    assign shifted   = full_word[WIDTH-2:0];
`endif

    // Next-state logic. The counter doubles as the IDLE/COLLECT state:
    // zero means no partial word is held.
    always_comb begin
        shift_next = shift_reg;
        cnt_next   = cnt_reg;
        word_next  = word_reg;
        val_next   = 1'b0;

        if (data_val_i) begin
            // Stale bits left after a completed word are pushed out by the
            // WIDTH-1 shifts of the next word, so no explicit clear is needed.
            shift_next = shifted;
            if (cnt_reg == LAST_CNT) begin
                cnt_next  = '0;
                word_next = full_word;
                val_next  = 1'b1;
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end

        busy_next = (cnt_next != '0);
    end

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            shift_reg <= '0;
            cnt_reg   <= '0;
            word_reg  <= '0;
            val_reg   <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            shift_reg <= shift_next;
            cnt_reg   <= cnt_next;
            word_reg  <= word_next;
            val_reg   <= val_next;
            busy_reg  <= busy_next;
        end
    end

    assign deser_data_o     = word_reg;
    assign deser_data_val_o = val_reg;
    assign busy_o           = busy_reg;

endmodule

// File: tb/tb_deserializer.sv
// -----------------------------------------------------------------------------
// tb_deserializer
//
// Directed testbench for the deserializer (WIDTH = 16). A queue-based model
// collects accepted bits and forms the expected word once 16 have arrived;
// a single compare process checks strobe, word and busy on every falling
// edge. Strobes seen on the DUT are logged so that each directed test can
// also be pinned with hand-computed literal words and strobe positions.
// Bit order follows DESER_LSB_FIRST_EN, the same macro as the design.
// -----------------------------------------------------------------------------
module tb_deserializer;

    localparam int W = 16;

    logic          clk        = 1'b0;
    logic          srst_i     = 1'b0;
    logic          data_i     = 1'b0;
    logic          data_val_i = 1'b0;
    logic [W-1:0]  deser_data_o;
    logic          deser_data_val_o;
    logic          busy_o;

    deserializer #(.WIDTH(W)) dut (
        .clk_i            (clk),
        .srst_i           (srst_i),
        .data_i           (data_i),
        .data_val_i       (data_val_i),
        .deser_data_o     (deser_data_o),
        .deser_data_val_o (deser_data_val_o),
        .busy_o           (busy_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit checking = 1'b0;

    // Model state: bits accepted so far for the current word, plus the
    // outputs that must be visible during the current cycle.
    logic         model_q[$];
    logic [W-1:0] m_data = '0;
    logic         m_val  = 1'b0;

    // Log of strobes actually produced by the DUT.
    logic [W-1:0] log_word[$];
    int           log_cyc[$];
    logic         log_busy[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] assemble();
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < W; i++) begin
`ifdef DESER_LSB_FIRST_EN
            w[i] = model_q[i];
`else
            w[W-1-i] = model_q[i];
`endif
        end
        return w;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Compare process: outputs are stable at the falling edge; afterwards the
    // model is advanced using the inputs the next rising edge will sample.
    initial forever begin
        @(negedge clk);
        if (srst_i) begin
            model_q.delete();
            m_data = '0;
            m_val  = 1'b0;
        end
        if (checking) begin
            chk("cyc_val",  {31'd0, deser_data_val_o}, {31'd0, m_val});
            chk("cyc_data", {16'd0, deser_data_o},     {16'd0, m_data});
            chk("cyc_busy", {31'd0, busy_o},           {31'd0, model_q.size() != 0});
        end
        if (deser_data_val_o) begin
            log_word.push_back(deser_data_o);
            log_cyc.push_back(cyc);
            log_busy.push_back(busy_o);
        end
        if (!srst_i) begin
            m_val = 1'b0;
            if (data_val_i) begin
                model_q.push_back(data_i);
                if (model_q.size() == W) begin
                    m_data = assemble();
                    m_val  = 1'b1;
                    model_q.delete();
                end
            end
        end
    end

    // Inputs change 1 ns after a rising edge and are sampled on the next one.
    task automatic send_bit(input logic b, input logic v);
        @(posedge clk);
        #1;
        data_i     = b;
        data_val_i = v;
    endtask

    task automatic idle(input int n);
        repeat (n) send_bit(1'b0, 1'b0);
    endtask

    // Sends w in the configured bit order; first = edge number sampling bit 0.
    task automatic send_word(input logic [W-1:0] w, input bit gaps, output int first);
        logic b;
        first = 0;
        for (int i = 0; i < W; i++) begin
`ifdef DESER_LSB_FIRST_EN
            b = w[i];
`else
            b = w[W-1-i];
`endif
            send_bit(b, 1'b1);
            if (i == 0) first = cyc + 1;
            if (gaps) send_bit(~b, 1'b0);
        end
    endtask

    task automatic clear_logs();
        log_word.delete();
        log_cyc.delete();
        log_busy.delete();
    endtask

    int           first;
    logic [W-1:0] lit_bits;
    logic [W-1:0] lit_exp;
    logic [W-1:0] words3[3];

    initial begin
        #1;
        srst_i   = 1'b1;
        checking = 1'b1;
        #1;
        chk("rst_data", {16'd0, deser_data_o}, 32'd0);
        chk("rst_val",  {31'd0, deser_data_val_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        srst_i = 1'b0;

        // Long idle with junk on data_i: nothing may be captured.
        clear_logs();
        for (int i = 0; i < 100; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        send_bit(1'b0, 1'b0);
        chk("idle_strobes", log_word.size(), 32'd0);
        chk("idle_data", {16'd0, deser_data_o}, 32'd0);
        chk("idle_busy", {31'd0, busy_o}, 32'd0);

        // One contiguous word.
        clear_logs();
        send_word(16'hA5C3, 1'b0, first);
        idle(3);
        chk("w1_strobes", log_word.size(), 32'd1);
        if (log_word.size() == 1) begin
            chk("w1_word", {16'd0, log_word[0]}, 32'h0000A5C3);
            chk("w1_offset", log_cyc[0] - first + 1, 32'd16);
            chk("w1_busy", {31'd0, log_busy[0]}, 32'd0);
        end

        // Literal bit stream 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 in arrival order.
        clear_logs();
        lit_bits = 16'b1100_0011_1010_0101;
`ifdef DESER_LSB_FIRST_EN
        lit_exp = 16'hA5C3;
`else
        lit_exp = 16'hC3A5;
`endif
        for (int i = 0; i < W; i++) send_bit(lit_bits[W-1-i], 1'b1);
        idle(3);
        chk("lit_strobes", log_word.size(), 32'd1);
        if (log_word.size() == 1) chk("lit_word", {16'd0, log_word[0]}, {16'd0, lit_exp});

        // Same word with a gap after every bit.
        clear_logs();
        send_word(16'hA5C3, 1'b1, first);
        idle(3);
        chk("gap_strobes", log_word.size(), 32'd1);
        if (log_word.size() == 1) begin
            chk("gap_word", {16'd0, log_word[0]}, 32'h0000A5C3);
            chk("gap_offset", log_cyc[0] - first + 1, 32'd31);
        end

        // Three words back-to-back with data_val_i held high.
        clear_logs();
        words3[0] = 16'h0001;
        words3[1] = 16'h8000;
        words3[2] = 16'hFFFF;
        begin
            int f;
            send_word(words3[0], 1'b0, first);
            send_word(words3[1], 1'b0, f);
            send_word(words3[2], 1'b0, f);
        end
        idle(3);
        chk("b2b_strobes", log_word.size(), 32'd3);
        if (log_word.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                chk("b2b_word", {16'd0, log_word[k]}, {16'd0, words3[k]});
                chk("b2b_offset", log_cyc[k] - first + 1, 32'(16 * (k + 1)));
                chk("b2b_busy", {31'd0, log_busy[k]}, 32'd0);
            end
        end

        // Reset in the middle of a word, then a clean word.
        clear_logs();
        for (int i = 0; i < 9; i++) send_bit(1'(i % 2), 1'b1);
        @(posedge clk);
        #1;
        data_val_i = 1'b0;
        #1;
        chk("mid_busy_before", {31'd0, busy_o}, 32'd1);
        srst_i = 1'b1;
        #1;
        chk("mid_rst_data", {16'd0, deser_data_o}, 32'd0);
        chk("mid_rst_val",  {31'd0, deser_data_val_o}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        @(posedge clk);
        #1;
        srst_i = 1'b0;
        send_word(16'h1234, 1'b0, first);
        idle(3);
        chk("mid_strobes", log_word.size(), 32'd1);
        if (log_word.size() == 1) begin
            chk("mid_word", {16'd0, log_word[0]}, 32'h00001234);
            chk("mid_offset", log_cyc[0] - first + 1, 32'd16);
        end

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
